// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Select encodings for data-path multiplexers, including the next-PC mux.
package data_path_muxs_pkg;

  localparam int PC_SEL_W = 3;

  // Encodings 5..7 are unused and fall back to sequential fetch.
  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEQ = 3'd0,
    PC_BR  = 3'd1,
    PC_JMP = 3'd2,
    PC_JR  = 3'd3,
    PC_RET = 3'd4
  } pc_mux_input_selection;

endpackage

// File: rtl/pc_stack_if.sv
// Bundle of the pc_stack signals, with one view for the block and one for a driver.
interface pc_stack_if
  import data_path_muxs_pkg::*;
#(
  parameter int PC_W = 32
) (
  input logic CLK
);

  logic                RST;
  logic                pc_wait;
  logic [PC_SEL_W-1:0] PCSrc;
  logic [15:0]         br_addr;
  logic [25:0]         jmp_addr;
  logic [PC_W-1:0]     jr_addr;
  logic                link;
  logic                redirect;
  logic [PC_W-1:0]     redirect_addr;
  logic [PC_W-1:0]     imemaddr;
  logic [PC_W-1:0]     npc;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_ovf;
  logic                ras_miss;

  modport pc_stack (
    input  CLK, RST, pc_wait, PCSrc, br_addr, jmp_addr, jr_addr, link,
           redirect, redirect_addr,
    output imemaddr, npc, ras_empty, ras_full, ras_ovf, ras_miss
  );

  modport tb (
    input  CLK, imemaddr, npc, ras_empty, ras_full, ras_ovf, ras_miss,
    output RST, pc_wait, PCSrc, br_addr, jmp_addr, jr_addr, link,
           redirect, redirect_addr
  );

endinterface

// File: rtl/ras_lifo.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry, so pops always come back newest-first and at most RAS_DEPTH
// addresses survive. ptr indexes the next free slot; the top entry sits at
// ptr-1. Entry storage is never reset: count alone decides validity.
module ras_lifo #(
  parameter int PC_W      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            ret_req,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            miss
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] count;
  logic             pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_MAX);
  assign top_idx  = ptr - PTR_ONE;
  assign top_data = mem[top_idx];
  // A push wins if both are ever requested together; the caller keeps them exclusive.
  assign pop      = ret_req && !push && !empty;

  // Pointer, occupancy and the one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      miss  <= 1'b0;
    end else begin
      ovf  <= push && full;
      miss <= ret_req && !push && empty;
      if (push) begin
        ptr <= ptr + PTR_ONE;
        if (!full) count <= count + CNT_ONE;
      end else if (pop) begin
        ptr   <= ptr - PTR_ONE;
        count <= count - CNT_ONE;
      end
    end
  end

  // Entry storage; written at the free slot, which is the oldest entry when full.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with next-PC mux and a return-address stack for
// linked jumps. Update priority: RST, then redirect, then pc_wait, then PCSrc.
module pc_stack
  import data_path_muxs_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_ADDR = '0,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                pc_wait,
  input  logic [PC_SEL_W-1:0] PCSrc,
  input  logic [15:0]         br_addr,
  input  logic [25:0]         jmp_addr,
  input  logic [PC_W-1:0]     jr_addr,
  input  logic                link,
  input  logic                redirect,
  input  logic [PC_W-1:0]     redirect_addr,
  output logic [PC_W-1:0]     imemaddr,
  output logic [PC_W-1:0]     npc,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_ovf,
  output logic                ras_miss
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] ras_top;
  logic            advance;
  logic            ras_push;
  logic            ras_ret;

  assign imemaddr   = pc_q;
  assign npc        = pc_q + PC_STEP;
  assign br_off     = {{(PC_W-18){br_addr[15]}}, br_addr, 2'b00};
  assign br_target  = npc + br_off;
  assign jmp_target = {npc[PC_W-1:28], jmp_addr, 2'b00};

  // The stack only moves on cycles where the PC takes its PCSrc choice.
  assign advance  = !redirect && !pc_wait;
  assign ras_push = advance && (PCSrc == PC_JMP) && link;
  assign ras_ret  = advance && (PCSrc == PC_RET);

  // Next-PC selection; a return with an empty stack falls back to jr_addr.
  always_comb begin
    pc_next = npc;
    case (PCSrc)
      PC_BR:   pc_next = br_target;
      PC_JMP:  pc_next = jmp_target;
      PC_JR:   pc_next = jr_addr;
      PC_RET:  pc_next = ras_empty ? jr_addr : ras_top;
      default: pc_next = npc;
    endcase
  end

  // PC register: redirect overrides a stall, a stall holds the PC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q <= RESET_ADDR;
    end else if (redirect) begin
      pc_q <= redirect_addr;
    end else if (!pc_wait) begin
      pc_q <= pc_next;
    end
  end

  ras_lifo #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (RST),
    .push      (ras_push),
    .ret_req   (ras_ret),
    .push_data (npc),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .miss      (ras_miss)
  );

endmodule
